toggle_cover_collector: RTL and testbench

- Synthesizable producer side of the toggle-coverage path: watches a WIDTH-bit signal, detects rising and falling transitions, and keeps sticky per-bit hit bitmaps.
- On request it drains the hit points one record per accepted beat over a valid/ready stream into the coverage sink. Each record is a cover index in the same COVER_INDEX-based index space the sink consumes.
- Used where DPI is unavailable (FPGA/emulation) and coverage is read out through a hardware channel.

---
 rtl/toggle_cover_collector.sv | 127 ++++++++++++
 tb/tb_toggle_cover_collector.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_cover_collector.sv
// rtl/toggle_cover_collector.sv - sticky rise/fall toggle hit bitmaps drained as cover-index records over a valid/ready stream
module toggle_cover_collector #(
    parameter int              WIDTH       = 28,
    parameter longint unsigned COVER_INDEX = 0,
    parameter int              IDX_W       = 64,
    localparam int             NE          = 2 * WIDTH,
    localparam int             PTR_W       = $clog2(NE),
    localparam int             CNT_W       = $clog2(2 * WIDTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  signal,
    input  logic              clear,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_fall,
    output logic              dump_done,
    output logic [CNT_W-1:0]  hit_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PTR_W-1:0] LAST = PTR_W'(NE - 1);

    state_t             state;
    logic [WIDTH-1:0]   prev;
    logic               prev_valid;
    logic [WIDTH-1:0]   rise_hit;
    logic [WIDTH-1:0]   fall_hit;
    logic [PTR_W-1:0]   ptr;
    logic               ptr_hit;

    function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Entry e maps to bit e>>1; the low bit selects the falling bitmap.
    always_comb begin
        ptr_hit = ptr[0] ? fall_hit[ptr[PTR_W-1:1]] : rise_hit[ptr[PTR_W-1:1]];
    end

    assign dump_busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            rise_hit   <= '0;
            fall_hit   <= '0;
            hit_count  <= '0;
        end else begin
            prev_valid <= enable;
            if (enable) begin
                prev <= signal;
            end
            // Clear outranks a same-cycle hit; it is dropped outright while a dump runs.
            if (clear && state == IDLE) begin
                rise_hit <= '0;
                fall_hit <= '0;
            end else if (enable && prev_valid) begin
                rise_hit <= rise_hit | (~prev & signal);
                fall_hit <= fall_hit | (prev & ~signal);
            end
            hit_count <= popcnt(rise_hit) + popcnt(fall_hit);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_fall  <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        ptr   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!out_valid) begin
                        if (ptr_hit) begin
                            out_valid <= 1'b1;
                            out_index <= IDX_W'(COVER_INDEX) + IDX_W'(ptr);
                            out_fall  <= ptr[0];
                        end else if (ptr == LAST) begin
                            state <= DONE;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (ptr == LAST) begin
                            state <= DONE;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    dump_done <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// tb/tb_toggle_cover_collector.sv - scoreboard bench for toggle_cover_collector
module tb_toggle_cover_collector;

    localparam int WIDTH = 28;
    localparam int IDX_W = 64;
    localparam int NE    = 2 * WIDTH;
    localparam int CNT_W = $clog2(2 * WIDTH + 1);

    logic              clock     = 1'b0;
    logic              reset     = 1'b0;
    logic              enable    = 1'b0;
    logic [WIDTH-1:0]  signal    = '0;
    logic              clear     = 1'b0;
    logic              dump_req  = 1'b0;
    logic              out_ready = 1'b0;
    logic              dump_busy;
    logic              out_valid;
    logic [IDX_W-1:0]  out_index;
    logic              out_fall;
    logic              dump_done;
    logic [CNT_W-1:0]  hit_count;

    toggle_cover_collector #(.WIDTH(WIDTH), .COVER_INDEX(0), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset), .enable(enable), .signal(signal),
        .clear(clear), .dump_req(dump_req), .dump_busy(dump_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_fall(out_fall), .dump_done(dump_done), .hit_count(hit_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int exp_q[$];

    // Reference: sticky sets of observed transitions; clr_expect marks a clear the test knows lands in IDLE.
    logic [WIDTH-1:0] mrise, mfall, mprev;
    bit               mpv;
    bit               clr_expect = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mrise <= '0;
            mfall <= '0;
            mprev <= '0;
            mpv   <= 0;
        end else begin
            if (clear && clr_expect) begin
                mrise <= '0;
                mfall <= '0;
            end else if (enable && mpv) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (mprev[i] == 1'b0 && signal[i] == 1'b1) mrise[i] <= 1'b1;
                    if (mprev[i] == 1'b1 && signal[i] == 1'b0) mfall[i] <= 1'b1;
                end
            end
            if (enable) mprev <= signal;
            mpv <= enable;
        end
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int model_count();
        return $countones(mrise) + $countones(mfall);
    endfunction

    task automatic push_model();
        for (int e = 0; e < NE; e++) begin
            if ((e % 2 == 1) ? mfall[e / 2] : mrise[e / 2]) exp_q.push_back(e);
        end
    endtask

    task automatic start_dump();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
    endtask

    task automatic wait_done(input bit rand_ready);
        int d0;
        bit got;
        d0  = done_seen;
        got = 0;
        for (int k = 0; k < 2000; k++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (dump_done) begin
                got = 1;
                break;
            end
        end
        out_ready = 1'b0;
        chk(got, "dump_done_timeout", got, 1);
        tick();
        chk(done_seen == d0 + 1, "dump_done_count", done_seen - d0, 1);
        chk(exp_q.size() == 0, "records_missing", exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold stability while stalled.
    initial begin
        bit               held;
        logic [IDX_W-1:0] hidx;
        int               e;
        held = 0;
        hidx = '0;
        forever begin
            @(negedge clock);
            if (dump_done) done_seen++;
            if (!reset) held = 0;
            if (held) begin
                chk(out_valid == 1'b1, "hold_valid", out_valid, 1);
                chk(out_index == hidx, "hold_index", out_index, hidx);
            end
            held = 0;
            if (reset && out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(0, "unexpected_record", out_index, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk(out_index == IDX_W'(e), "rec_index", out_index, e);
                        chk(out_fall == e[0], "rec_fall", out_fall, e[0]);
                    end
                end else begin
                    held = 1;
                    hidx = out_index;
                end
            end
        end
    end

    initial begin
        int n;
        bit busy_ok, any_valid, got;
        int d0;

        // Reset held with the input toggling.
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            signal = WIDTH'($urandom);
            tick();
        end
        chk(out_valid == 0, "rst_out_valid", out_valid, 0);
        chk(out_index == 0, "rst_out_index", out_index, 0);
        chk(out_fall == 0, "rst_out_fall", out_fall, 0);
        chk(dump_done == 0, "rst_dump_done", dump_done, 0);
        chk(dump_busy == 0, "rst_dump_busy", dump_busy, 0);
        chk(hit_count == 0, "rst_hit_count", hit_count, 0);

        // First enabled cycle only arms.
        reset  = 1'b1;
        signal = '1;
        tick(); tick(); tick();
        chk(hit_count == 0, "first_cycle_arms_only", hit_count, 0);
        signal = '0; clear = 1'b1; clr_expect = 1;
        tick();
        clear = 1'b0; clr_expect = 0;
        tick(); tick();
        chk(hit_count == 0, "clear_wins_over_falls", hit_count, 0);

        // bit3 rise then fall.
        signal[3] = 1'b1; tick();
        signal[3] = 1'b0; tick();
        tick(); tick();
        chk(hit_count == 2, "bit3_hit_count", hit_count, 2);
        exp_q.push_back(6); exp_q.push_back(7);
        start_dump();
        wait_done(0);

        // Same hits, sink stalls for 5 cycles.
        exp_q.push_back(6); exp_q.push_back(7);
        start_dump();
        out_ready = 1'b0;
        got = 0;
        for (int k = 0; k < 100; k++) begin
            if (out_valid) begin got = 1; break; end
            tick();
        end
        chk(got, "stall_valid_timeout", got, 1);
        for (int k = 0; k < 5; k++) begin
            chk(out_valid == 1, "stall_valid", out_valid, 1);
            chk(out_index == 6, "stall_index", out_index, 6);
            tick();
        end
        wait_done(0);
        chk(hit_count == 2, "nondestructive_count", hit_count, 2);

        // Empty dump timing.
        clear = 1'b1; clr_expect = 1; tick();
        clear = 1'b0; clr_expect = 0; tick(); tick();
        chk(hit_count == 0, "idle_clear", hit_count, 0);
        dump_req = 1'b1; tick(); dump_req = 1'b0;
        out_ready = 1'b1;
        n = 0; busy_ok = 1; any_valid = 0;
        while (!dump_done && n < 200) begin
            busy_ok   &= dump_busy;
            any_valid |= out_valid;
            tick();
            n++;
        end
        chk(n == 2 * WIDTH + 1, "empty_done_latency", n, 2 * WIDTH + 1);
        chk(busy_ok, "empty_busy_high", busy_ok, 1);
        chk(!any_valid, "empty_no_records", any_valid, 0);
        chk(dump_busy == 0, "busy_low_at_done", dump_busy, 0);
        tick();

        // Hits arriving mid-dump: entry 0 behind ptr, entry 55 ahead.
        enable = 1'b0; signal = WIDTH'(1) << 27; tick();
        enable = 1'b1; tick(); tick();
        chk(hit_count == 0, "bit27_armed_no_hit", hit_count, 0);
        start_dump();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        signal = WIDTH'(1);
        exp_q.push_back(55);
        wait_done(0);
        chk(hit_count == 2, "mid_dump_count", hit_count, 2);
        push_model();
        chk(exp_q.size() == 2, "model_second_dump_size", exp_q.size(), 2);
        start_dump();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        clear = 1'b1; tick(); clear = 1'b0;
        wait_done(1);
        chk(hit_count == 2, "busy_clear_ignored", hit_count, 2);

        // Clear in IDLE alongside a rising toggle.
        signal = signal | (WIDTH'(1) << 5);
        clear = 1'b1; clr_expect = 1; tick();
        clear = 1'b0; clr_expect = 0; tick(); tick();
        chk(hit_count == 0, "clear_beats_new_hit", hit_count, 0);
        chk(int'(hit_count) == model_count(), "clear_model_count", hit_count, model_count());

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 30; k++) begin
                enable = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 2) == 0) signal[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
                if ($urandom_range(0, 39) == 0) begin clear = 1'b1; clr_expect = 1; end
                tick();
                clear = 1'b0; clr_expect = 0;
            end
            tick(); tick();
            chk(int'(hit_count) == model_count(), "rand_hit_count", hit_count, model_count());
            push_model();
            start_dump();
            wait_done(1);
        end

        // Reset in the middle of a dump.
        enable = 1'b1;
        signal[10] ^= 1'b1; tick();
        signal[10] ^= 1'b1; tick(); tick();
        push_model();
        start_dump();
        out_ready = 1'b0;
        got = 0;
        for (int k = 0; k < 200; k++) begin
            if (out_valid) begin got = 1; break; end
            tick();
        end
        chk(got, "rst_dump_valid_timeout", got, 1);
        reset = 1'b0;
        #2;
        chk(out_valid == 0, "async_rst_valid", out_valid, 0);
        chk(dump_busy == 0, "async_rst_busy", dump_busy, 0);
        chk(hit_count == 0, "async_rst_count", hit_count, 0);
        exp_q.delete();
        d0 = done_seen;
        tick(); tick(); tick();
        reset = 1'b1;
        out_ready = 1'b1;
        any_valid = 0;
        for (int k = 0; k < 80; k++) begin
            any_valid |= out_valid;
            tick();
        end
        chk(done_seen == d0, "no_done_after_reset", done_seen - d0, 0);
        chk(!any_valid, "no_record_after_reset", any_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
